vec_mem_arbiter: RTL
====================

VEC_MEM_ARBITER -- requirements
Module: vec_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64, is the number of grant cycles without mem_ready before an aborted response (range 2..65535).
REQ-002 Parameter FIXED_VEC_PRIO, default 0: 0 selects round-robin arbitration, 1 gives the vec port priority on every conflict.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 resetn  in  1  synchronous, active-low reset.
REQ-005 cpu_valid  in  1  CPU request, held until cpu_ready.
REQ-006 cpu_addr  in  32  CPU byte address.
REQ-007 cpu_wdata  in  32  CPU write data.
REQ-008 cpu_wstrb  in  4  CPU byte strobes; 0 means read.
REQ-009 cpu_ready  out  1  one-cycle completion pulse to the CPU.
REQ-010 cpu_rdata  out  32  CPU read data, valid when cpu_ready=1.
REQ-011 vec_valid  in  1  vector-coprocessor request, held until vec_ready.
REQ-012 vec_addr  in  32  vec byte address.
REQ-013 vec_wdata  in  32  vec write data.
REQ-014 vec_wstrb  in  4  vec byte strobes; 0 means read.
REQ-015 vec_ready  out  1  one-cycle completion pulse to the vec port.
REQ-016 vec_rdata  out  32  vec read data, valid when vec_ready=1.
REQ-017 mem_valid  out  1  shared-memory request.
REQ-018 mem_addr  out  32  shared-memory address.
REQ-019 mem_wdata  out  32  shared-memory write data.
REQ-020 mem_wstrb  out  4  shared-memory strobes.
REQ-021 mem_ready  in  1  shared-memory one-cycle completion pulse.
REQ-022 mem_rdata  in  32  shared-memory read data.
REQ-023 timeout_err  out  1  one-cycle pulse on an aborted transaction.

Function
REQ-024 The FSM SHALL have three states: IDLE, GNT_CPU and GNT_VEC; only one transaction is outstanding at a time.
REQ-025 In IDLE, a request on exactly one port SHALL move the FSM to that port's GNT state on the next edge.
REQ-026 In IDLE with both ports requesting, round-robin mode SHALL grant the port not served last (last_vec register, reset 0, so the vec port wins the first conflict), and FIXED_VEC_PRIO=1 SHALL always grant vec.
REQ-027 In GNT_x, mem_valid/addr/wdata/wstrb SHALL equal the granted port's inputs combinationally; in IDLE mem_valid=0.
REQ-028 mem_ready and mem_rdata SHALL pass combinationally to the granted port's ready and rdata; the non-granted port's ready SHALL be 0 and its rdata 0.
REQ-029 The FSM SHALL go from GNT_x to IDLE on the edge after mem_ready=1, updating last_vec, so mem_valid drops the cycle after mem_ready.
REQ-030 Latency with a zero-wait memory SHALL be: request seen at cycle N, mem_valid at N+1, mem_ready and port ready at N+2, IDLE at N+3.
REQ-031 The grant SHALL be held until mem_ready or timeout even if the granted port's valid drops; that is a protocol violation and does not abort the transaction.
REQ-032 The 16-bit wait counter SHALL clear on entry to GNT_x and increment every grant cycle without mem_ready.
REQ-033 When the counter equals TIMEOUT-1 and mem_ready=0, the arbiter SHALL in that cycle drive the granted port ready=1 and rdata=0, force mem_valid=0, pulse timeout_err, and return to IDLE.
REQ-034 If mem_ready and the timeout fall in the same cycle, mem_ready SHALL win and timeout_err SHALL stay 0.
REQ-035 A mem_ready arriving in IDLE SHALL be ignored.

Reset
REQ-036 While resetn=0 at a clock edge, the arbiter SHALL reset FSM=IDLE, last_vec=0 and counter=0; all outputs then read 0 (mem_valid, cpu_ready, vec_ready and timeout_err are 0).
REQ-037 Reset during GNT_x SHALL abandon the transaction with no ready pulse to either port.

Structure
REQ-038 The FSM state encoding and the default TIMEOUT constant SHALL live in the shared vec_pkg package.
REQ-039 The design SHALL be a single module with no sub-modules; the port mux is inline.

Verification
REQ-040 CPU-only read of addr 400 with a zero-wait memory -> cpu_ready 2 cycles after cpu_valid, cpu_rdata=memory[100]=0x04030201, vec_ready=0 throughout.
REQ-041 cpu_valid and vec_valid raised in the same cycle, round-robin -> vec served first, CPU granted the cycle after IDLE; repeating the conflict alternates CPU, vec, CPU.
REQ-042 The same conflict with FIXED_VEC_PRIO=1 under back-to-back vec requests -> vec always wins and the CPU is granted only in an IDLE cycle with no vec request.
REQ-043 vec write of 0xDEADBEEF, wstrb 4'b0011, addr 440 -> mem_wstrb=4'b0011, memory[110]=0x0000BEEF, vec_ready pulses once.
REQ-044 CPU read at addr 2000 (memory never answers), TIMEOUT=8 -> cpu_ready=1 with cpu_rdata=0 and timeout_err=1 exactly 8 cycles after grant, then IDLE.
REQ-045 resetn driven low during GNT_VEC -> next cycle IDLE, all outputs 0, no vec_ready pulse; a new CPU request after reset is served normally.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared definitions for the vector/CPU memory arbiter: FSM encoding and defaults.
package vec_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGntCpu = 2'd1,
        StGntVec = 2'd2
    } arb_state_e;

    localparam int unsigned DefaultTimeout = 64;
    localparam int unsigned CntW           = 16;

endpackage

// File: rtl/vec_mem_arbiter.sv
// Two-port (CPU, vector coprocessor) arbiter in front of one shared memory port,
// one transaction outstanding at a time, with a grant-cycle timeout.
module vec_mem_arbiter
    import vec_pkg::*;
#(
    parameter int unsigned TIMEOUT        = DefaultTimeout,
    parameter bit          FIXED_VEC_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_valid,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    input  logic        vec_valid,
    input  logic [31:0] vec_addr,
    input  logic [31:0] vec_wdata,
    input  logic [3:0]  vec_wstrb,
    output logic        vec_ready,
    output logic [31:0] vec_rdata,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        timeout_err
);

    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    arb_state_e      state_q;
    logic            last_vec_q;
    logic [CntW-1:0] cnt_q;

    logic gnt_cpu, gnt_vec, timeout_hit;

    // Grants are masked while resetn is low so an abandoned transaction never completes.
    assign gnt_cpu     = resetn && (state_q == StGntCpu);
    assign gnt_vec     = resetn && (state_q == StGntVec);
    assign timeout_hit = (gnt_cpu || gnt_vec) && !mem_ready && (cnt_q == CntLast);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= StIdle;
            last_vec_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (cpu_valid && vec_valid) begin
                        state_q <= (FIXED_VEC_PRIO || !last_vec_q) ? StGntVec : StGntCpu;
                    end else if (vec_valid) begin
                        state_q <= StGntVec;
                    end else if (cpu_valid) begin
                        state_q <= StGntCpu;
                    end
                end
                StGntCpu, StGntVec: begin
                    if (mem_ready || cnt_q == CntLast) begin
                        state_q    <= StIdle;
                        last_vec_q <= (state_q == StGntVec);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        mem_valid   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        cpu_ready   = 1'b0;
        cpu_rdata   = '0;
        vec_ready   = 1'b0;
        vec_rdata   = '0;
        timeout_err = timeout_hit;
        if (gnt_cpu) begin
            mem_valid = !timeout_hit;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_wstrb = cpu_wstrb;
            cpu_ready = mem_ready || timeout_hit;
            cpu_rdata = timeout_hit ? '0 : mem_rdata;
        end else if (gnt_vec) begin
            mem_valid = !timeout_hit;
            mem_addr  = vec_addr;
            mem_wdata = vec_wdata;
            mem_wstrb = vec_wstrb;
            vec_ready = mem_ready || timeout_hit;
            vec_rdata = timeout_hit ? '0 : mem_rdata;
        end
    end

endmodule
